// File: rtl/axis_frame_wrapper.sv
// axis_frame_wrapper
// Wraps each AXI-Stream packet from the TX mux into a frame:
//   header  {MAGIC, seq, tuser}  -> payload beats unchanged -> trailer {err, count, chk}.
// Packets longer than MAX_BEATS are cut at MAX_BEATS. The rest of the packet is discarded,
// and the trailer err bit is set.
// Optional feature: define AXIS_FRAME_SEQ_EN to add an 8-bit sequence number to the header.
// Without it the seq field is constant 0.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (released synchronously inside)
//   s_tvalid/s_tready/s_tlast/s_tuser/s_tdata   upstream AXIS slave
//   m_tvalid/m_tready/m_tlast/m_tuser/m_tdata   downstream AXIS master (combinational from state)
//   truncated         one-cycle pulse after a truncated frame's trailer is accepted
//   frameCount        number of accepted trailers, wraps at 16'hFFFF
module axis_frame_wrapper #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned USER_WIDTH = 8,
   parameter logic [15:0] MAGIC      = 16'hA5C3,
   parameter int unsigned MAX_BEATS  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic                  s_tlast,
   input  logic [USER_WIDTH-1:0] s_tuser,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic [USER_WIDTH-1:0] m_tuser,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  truncated,
   output logic [15:0]           frameCount
);

   localparam int unsigned CNT_W = 15;

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_PAY  = 2'd1,
      ST_TRL  = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [1:0]            r_rst_pipe;
   logic                  w_rst_hold;
   logic                  w_gate;
   logic [CNT_W-1:0]      r_count;
   logic [CNT_W-1:0]      w_count_inc;
   logic [15:0]           r_chk;
   logic [15:0]           w_fold;
   logic                  r_err;
   logic                  r_drop_pending;
   logic [USER_WIDTH-1:0] r_tuser;
   logic [7:0]            w_seq;
   logic [DATA_WIDTH-1:0] w_header;
   logic [DATA_WIDTH-1:0] w_trailer;
   logic                  w_hdr_fire;
   logic                  w_pay_fire;
   logic                  w_trl_fire;
   logic                  w_drop_end;
   logic                  w_max_hit;

   // Reset release synchronizer: rst asserts immediately, deassertion is seen two edges later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rst_pipe <= 2'b11;
      else     r_rst_pipe <= {r_rst_pipe[0], 1'b0};
   end

   assign w_rst_hold = r_rst_pipe[1];
   assign w_gate     = rst | w_rst_hold;

`ifdef AXIS_FRAME_SEQ_EN
   logic [7:0] r_seq;

   // Frame sequence number, advances on every accepted trailer
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_seq <= 8'd0;
      else if (w_rst_hold) r_seq <= 8'd0;
      else if (w_trl_fire) r_seq <= r_seq + 8'd1;
   end

   assign w_seq = r_seq;
`else
   assign w_seq = 8'd0;
`endif

   assign w_fold      = s_tdata[31:16] ^ s_tdata[15:0];
   assign w_count_inc = r_count + CNT_W'(1);
   assign w_max_hit   = (w_count_inc == CNT_W'(MAX_BEATS));
   assign w_header    = DATA_WIDTH'({MAGIC, w_seq, 8'(s_tuser)});
   assign w_trailer   = DATA_WIDTH'({r_err, r_count, r_chk});

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_state <= ST_HDR;
      else if (w_rst_hold) r_state <= ST_HDR;
      else                 r_state <= w_state_nxt;
   end

   // Next state and combinational stream outputs
   always_comb begin
      w_state_nxt = r_state;
      m_tvalid    = 1'b0;
      s_tready    = 1'b0;
      m_tlast     = 1'b0;
      m_tdata     = '0;
      m_tuser     = r_tuser;
      w_hdr_fire  = 1'b0;
      w_pay_fire  = 1'b0;
      w_trl_fire  = 1'b0;
      w_drop_end  = 1'b0;
      case (r_state)
         ST_HDR: begin
            // Header is emitted only once the first payload beat is waiting
            m_tvalid = s_tvalid;
            m_tdata  = w_header;
            m_tuser  = s_tuser;
            if (s_tvalid && m_tready) begin
               w_hdr_fire  = 1'b1;
               w_state_nxt = ST_PAY;
            end
         end
         ST_PAY: begin
            m_tvalid = s_tvalid;
            s_tready = m_tready;
            m_tdata  = s_tdata;
            if (s_tvalid && m_tready) begin
               w_pay_fire = 1'b1;
               if (s_tlast || w_max_hit) w_state_nxt = ST_TRL;
            end
         end
         ST_TRL: begin
            m_tvalid = 1'b1;
            m_tlast  = 1'b1;
            m_tdata  = w_trailer;
            if (m_tready) begin
               w_trl_fire  = 1'b1;
               w_state_nxt = r_drop_pending ? ST_DROP : ST_HDR;
            end
         end
         ST_DROP: begin
            s_tready = 1'b1;
            if (s_tvalid && s_tlast) begin
               w_drop_end  = 1'b1;
               w_state_nxt = ST_HDR;
            end
         end
         default: w_state_nxt = ST_HDR;
      endcase
      if (w_gate) begin
         m_tvalid = 1'b0;
         s_tready = 1'b0;
      end
   end

   // Frame bookkeeping: tag, beat count, checksum, truncation flags, counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tuser        <= '0;
         r_count        <= '0;
         r_chk          <= 16'd0;
         r_err          <= 1'b0;
         r_drop_pending <= 1'b0;
         truncated      <= 1'b0;
         frameCount     <= 16'd0;
      end else if (w_rst_hold) begin
         r_tuser        <= '0;
         r_count        <= '0;
         r_chk          <= 16'd0;
         r_err          <= 1'b0;
         r_drop_pending <= 1'b0;
         truncated      <= 1'b0;
         frameCount     <= 16'd0;
      end else begin
         truncated <= w_trl_fire & r_err;
         if (w_hdr_fire) begin
            r_tuser <= s_tuser;
            r_count <= '0;
            r_chk   <= 16'd0;
            r_err   <= 1'b0;
         end
         if (w_pay_fire) begin
            r_count <= w_count_inc;
            r_chk   <= r_chk ^ w_fold;
            // tlast on the MAX_BEATS-th beat is a clean end, not a truncation
            if (!s_tlast && w_max_hit) begin
               r_err          <= 1'b1;
               r_drop_pending <= 1'b1;
            end
         end
         if (w_trl_fire) frameCount <= frameCount + 16'd1;
         if (w_drop_end) r_drop_pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_frame_wrapper.sv
// Testbench for axis_frame_wrapper (MAX_BEATS=4): scoreboard of expected frame words
module tb_axis_frame_wrapper;

   localparam int unsigned MAX = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  user;
      logic        last;
      logic        ctl;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic [7:0]  s_tuser;
   logic [31:0] s_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic [7:0]  m_tuser;
   logic [31:0] m_tdata;
   logic        truncated;
   logic [15:0] frameCount;

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        exp_q[$];
   logic [31:0] pkt_q[$];
   logic [7:0]  seq_m = 8'd0;
   logic [15:0] fc_m = 16'd0;
   logic        trunc_exp = 1'b0;

   axis_frame_wrapper #(
      .DATA_WIDTH(32), .USER_WIDTH(8), .MAGIC(16'hA5C3), .MAX_BEATS(MAX)
   ) dut (
      .clk(clk), .rst(rst),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .s_tuser(s_tuser), .s_tdata(s_tdata),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .m_tuser(m_tuser), .m_tdata(m_tdata),
      .truncated(truncated), .frameCount(frameCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Builds the expected frame for pkt_q, then drives it and scores every output cycle
   task automatic run_pkt(input logic [7:0] user, input bit toggle);
      int          n = pkt_q.size();
      int          emit;
      bit          trunc;
      logic [15:0] chk = 16'd0;
      int          idx = 0;
      int          cyc = 0;
      bit          stall = 1'b0;
      bit          fire;
      logic [41:0] held = '0;
      exp_t        e;
      trunc = (n > int'(MAX));
      emit  = trunc ? int'(MAX) : n;
      exp_q.push_back('{data: {16'hA5C3, seq_m, user}, user: user, last: 1'b0, ctl: 1'b1, err: 1'b0});
      for (int i = 0; i < emit; i++) begin
         exp_q.push_back('{data: pkt_q[i], user: user, last: 1'b0, ctl: 1'b0, err: 1'b0});
         chk = chk ^ pkt_q[i][31:16] ^ pkt_q[i][15:0];
      end
      exp_q.push_back('{data: {trunc, 15'(emit), chk}, user: user, last: 1'b1, ctl: 1'b1, err: trunc});

      s_tvalid = 1'b1;
      s_tdata  = pkt_q[0];
      s_tlast  = (n == 1);
      s_tuser  = user;
      m_tready = 1'b1;
      while ((idx < n || exp_q.size() != 0) && cyc < 100) begin
         @(negedge clk);
         cyc++;
         check("truncated", 64'(truncated), 64'(trunc_exp));
         trunc_exp = 1'b0;
         check("frameCount", 64'(frameCount), 64'(fc_m));
         if (stall) check("hold", 64'({m_tvalid, m_tlast, m_tuser, m_tdata}), 64'(held));
         if (m_tvalid && exp_q.size() != 0 && exp_q[0].ctl)
            check("s_tready_ctl", 64'(s_tready), 64'(0));
         stall = m_tvalid && !m_tready;
         held  = {1'b1, m_tlast, m_tuser, m_tdata};
         if (m_tvalid && m_tready) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL extra_word: observed %0h expected none", m_tdata);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("m_tdata", 64'(m_tdata), 64'(e.data));
               check("m_tuser", 64'(m_tuser), 64'(e.user));
               check("m_tlast", 64'(m_tlast), 64'(e.last));
               if (e.last) begin
                  fc_m      = fc_m + 16'd1;
                  trunc_exp = e.err;
`ifdef AXIS_FRAME_SEQ_EN
                  seq_m = seq_m + 8'd1;
`endif
               end
            end
         end
         fire = s_tvalid && s_tready;
         @(posedge clk);
         #1;
         if (fire) idx++;
         s_tvalid = (idx < n);
         if (idx < n) begin
            s_tdata = pkt_q[idx];
            s_tlast = (idx == n - 1);
         end else begin
            s_tlast = 1'b0;
         end
         if (toggle) m_tready = !m_tready;
      end
      n_tests++;
      assert (cyc < 100) else begin
         n_fail++;
         $error("FAIL timeout: observed %0d cycles expected < 100", cyc);
      end
      @(negedge clk);
      check("truncated_end", 64'(truncated), 64'(trunc_exp));
      trunc_exp = 1'b0;
      check("frameCount_end", 64'(frameCount), 64'(fc_m));
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      exp_q.delete();
      pkt_q.delete();
   endtask

   initial begin
      rst      = 1'b1;
      s_tvalid = 1'b1;
      s_tlast  = 1'b0;
      s_tuser  = 8'd0;
      s_tdata  = 32'h0;
      m_tready = 1'b1;
      #3;
      check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_s_tready", 64'(s_tready), 64'(0));
      check("rst_frameCount", 64'(frameCount), 64'(0));
      check("rst_truncated", 64'(truncated), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      s_tvalid = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // 3-beat packet, downstream always ready
      pkt_q = '{32'h00010002, 32'h00030004, 32'h12345678};
      run_pkt(8'd5, 1'b0);
      // same packet with m_tready toggling
      pkt_q = '{32'h00010002, 32'h00030004, 32'h12345678};
      run_pkt(8'd5, 1'b1);
      // over-long packet: truncated at MAX, remainder dropped
      pkt_q = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004,
                32'hA0000005, 32'hA0000006, 32'hA0000007};
      run_pkt(8'd9, 1'b0);
      // following packet framed normally
      pkt_q = '{32'hDEADBEEF, 32'h0F0F1234};
      run_pkt(8'd3, 1'b0);
      // exactly MAX beats with tlast on the last one: clean end
      pkt_q = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
      run_pkt(8'd4, 1'b1);
      // two single-beat packets
      pkt_q = '{32'hCAFEF00D};
      run_pkt(8'd1, 1'b0);
      pkt_q = '{32'h00000001};
      run_pkt(8'd2, 1'b0);

      // reset in the middle of a payload
      s_tvalid = 1'b1;
      s_tdata  = 32'hB0000000;
      s_tlast  = 1'b0;
      s_tuser  = 8'd6;
      m_tready = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      s_tdata = 32'hB0000001;
      @(posedge clk);
      #1;
      s_tdata = 32'hB0000002;
      check("pre_rst_m_tvalid", 64'(m_tvalid), 64'(1));
      rst = 1'b1;
      #1;
      check("midrst_m_tvalid", 64'(m_tvalid), 64'(0));
      check("midrst_s_tready", 64'(s_tready), 64'(0));
      check("midrst_frameCount", 64'(frameCount), 64'(0));
      fc_m      = 16'd0;
      seq_m     = 8'd0;
      trunc_exp = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      s_tvalid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      pkt_q = '{32'h01020304, 32'h05060708};
      run_pkt(8'd7, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_frame_wrapper.md
Name: axis_frame_wrapper

Overview:
- Sits directly downstream of the multi-source AXIS mux on the cell-comm TX path. Consumes the mux's merged packet stream and emits framed packets toward the serial link.
- Each frame is a header word, then the payload beats unchanged, then a trailer word holding the beat count and a 16-bit XOR checksum.
- Over-long packets are truncated to MAX_BEATS. The rest of that packet is dropped and the error is flagged in the trailer.

Parameters:
- DATA_WIDTH, 32, data width; must be >= 32; bits above 31 of header/trailer are zero.
- USER_WIDTH, 8, tuser width; must be <= 8.
- MAGIC, 16'hA5C3, header sync pattern.
- MAX_BEATS, 256, max payload beats per frame; range 1..32767.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- s_tvalid  in  1  upstream valid.
- s_tready  out  1  upstream ready.
- s_tlast  in  1  end of upstream packet.
- s_tuser  in  USER_WIDTH  source tag.
- s_tdata  in  DATA_WIDTH  payload.
- m_tvalid  out  1  downstream valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  asserted on the trailer beat only.
- m_tuser  out  USER_WIDTH  tag latched from the first payload beat, held for the whole frame.
- m_tdata  out  DATA_WIDTH  header / payload / trailer.
- truncated  out  1  one-cycle pulse when a frame is truncated.
- frameCount  out  16  count of trailers accepted downstream; wraps at 16'hFFFF.

Behaviour:
- Reset (async assert, sync-released internally):
  - state=HDR; beat counter, checksum, sequence, frameCount all 0; truncated=0.
  - While rst is high, m_tvalid=0 and s_tready=0, gated combinationally.
  - A reset mid-frame abandons the frame with no trailer.
- Header word: {MAGIC[15:0], seq[7:0], zero-extended s_tuser[7:0]}, taken from the pending first payload beat.
- Trailer word: {err, count[14:0], chk[15:0]}.
  - count = payload beats emitted.
  - chk = XOR over the payload of data[31:16]^data[15:0].
  - err = 1 when the frame was truncated.
- A frame is never started without data; empty frames are impossible.
- Beat transfer = valid && ready on the same interface. Zero added latency: all data paths are combinational from state registers.

FSM:
- HDR:
  - m_tvalid=s_tvalid, m_tdata=header, m_tuser=s_tuser, m_tlast=0, s_tready=0.
  - On m_tvalid&&m_tready: latch tuser, clear count and chk, go to PAY.
- PAY:
  - m_tvalid=s_tvalid, s_tready=m_tready, m_tdata=s_tdata, m_tlast=0.
  - On each transfer: count+=1, chk^=fold(data).
  - If s_tlast on the transfer: go to TRL with err=0.
  - Else if count reaches MAX_BEATS (count+1==MAX_BEATS on the transfer): go to TRL with err=1 and dropPending=1.
  - s_tlast on the MAX_BEATS-th beat counts as a normal end: err=0.
- TRL:
  - m_tvalid=1, m_tlast=1, m_tdata=trailer, s_tready=0.
  - On m_tready: frameCount+=1; seq+=1 (feature dependent); truncated pulses in the cycle after acceptance if err.
  - Next state: DROP if dropPending, else HDR.
- DROP:
  - s_tready=1, m_tvalid=0.
  - Discard beats. On s_tvalid&&s_tlast: go to HDR, clear dropPending.
- Stalls and holds:
  - m_tready low holds the current word stable.
  - s_tvalid dropping mid-PAY simply stalls with no error.
- Wraps:
  - The count field reports exactly MAX_BEATS on truncation.
  - seq wraps 255->0.
  - frameCount wraps 16'hFFFF->0.

Optional Feature:
- Macro: AXIS_FRAME_SEQ_EN.
  - Defined: an 8-bit sequence register increments on each accepted trailer and is placed in header bits [15:8].
  - Undefined: the seq field is constant 0 and no sequence register is synthesized.

Test Plan:
- 3-beat packet (0x00010002, 0x00030004, 0x12345678), tuser=5, m_tready=1 ->
  - header 0xA5C30005 (seq 0);
  - payload unchanged;
  - trailer {0, 3, 0x0003^0x0004^0x0001^0x0002^0x1234^0x5678} with m_tlast=1;
  - frameCount=1.
- Same packet with m_tready toggling 1/0 every cycle -> identical 5-word output; every word held stable while stalled; s_tready never high in HDR/TRL.
- MAX_BEATS=4, 7-beat packet -> header, 4 payload beats, trailer err=1 count=4, truncated pulses once, beats 5-7 dropped; next packet framed normally.
- Two back-to-back 1-beat packets with tuser 1 then 2, AXIS_FRAME_SEQ_EN defined -> headers 0xA5C30001 then 0xA5C30102; frameCount=2.
- rst asserted mid-PAY after 2 beats -> m_tvalid and s_tready drop immediately, no trailer; after release the next packet gets seq=0 and frameCount=0 until its trailer is accepted.
- Packet of exactly MAX_BEATS beats with tlast on the last beat -> trailer err=0, no truncated pulse, no DROP.
